// File: rtl/cubehash_pkg.sv
// Shared CubeHash types, constants and the pure single-round function
// used by both the round datapath and any reference-model hooks.
package cubehash_pkg;

    typedef logic [31:0]   word_t;
    typedef logic [1023:0] state_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

    localparam int unsigned ROT_A   = 32'd7;
    localparam int unsigned ROT_B   = 32'd11;
    localparam word_t       FIN_XOR = 32'h0000_0001;

    function automatic word_t rotl(input word_t w, input int unsigned n);
        return (w << n) | (w >> (32'd32 - n));
    endfunction

    // The four swap steps are index permutations: flipping one index bit
    // (j, l, k, m respectively) within the relevant half of the state.
    function automatic state_t cube_round(input state_t s);
        word_t  x [32];
        word_t  t [32];
        state_t r;
        for (int i = 0; i < 32; i++) x[5'(i)] = s[32*i +: 32];
        for (int i = 0; i < 16; i++) x[5'(i + 16)] = x[5'(i + 16)] + x[5'(i)];
        for (int i = 0; i < 16; i++) x[5'(i)] = rotl(x[5'(i)], ROT_A);
        t = x;
        for (int i = 0; i < 16; i++) t[5'(i)] = x[5'(i ^ 8)];
        x = t;
        for (int i = 0; i < 16; i++) x[5'(i)] = x[5'(i)] ^ x[5'(i + 16)];
        t = x;
        for (int i = 16; i < 32; i++) t[5'(i)] = x[5'(i ^ 2)];
        x = t;
        for (int i = 0; i < 16; i++) x[5'(i + 16)] = x[5'(i + 16)] + x[5'(i)];
        for (int i = 0; i < 16; i++) x[5'(i)] = rotl(x[5'(i)], ROT_B);
        t = x;
        for (int i = 0; i < 16; i++) t[5'(i)] = x[5'(i ^ 4)];
        x = t;
        for (int i = 0; i < 16; i++) x[5'(i)] = x[5'(i)] ^ x[5'(i + 16)];
        t = x;
        for (int i = 16; i < 32; i++) t[5'(i)] = x[5'(i ^ 1)];
        x = t;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = x[5'(i)];
        return r;
    endfunction

endpackage

// File: rtl/cubehash_round.sv
// One purely combinational CubeHash round; chained UNROLL times by the top.
module cubehash_round
    import cubehash_pkg::*;
(
    input  state_t state_in,
    output state_t state_out
);

    assign state_out = cube_round(state_in);

endmodule

// File: rtl/cubehash_perm.sv
// Iterative CubeHash permutation engine: start/busy/done handshake,
// UNROLL rounds per clock, optional finalisation call.
module cubehash_perm
    import cubehash_pkg::*;
#(
    parameter int ROUNDS   = 16,
    parameter int UNROLL   = 1,
    parameter int FIN_MULT = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          fin,
    input  logic [1023:0] state_in,
    output logic          busy,
    output logic          done,
    output logic [1023:0] state_out
);

    localparam int N_NORM = ROUNDS / UNROLL;
    localparam int N_FIN  = FIN_MULT * ROUNDS / UNROLL;
    localparam int CW_RAW = $clog2(N_FIN);
    localparam int CW     = (CW_RAW < 32'sd1) ? 32'sd1 : CW_RAW;
    localparam logic [CW-1:0] CNT_NORM = CW'(N_NORM - 32'sd1);
    localparam logic [CW-1:0] CNT_FIN  = CW'(N_FIN - 32'sd1);

    if (ROUNDS < 32'sd1 || UNROLL < 32'sd1 || FIN_MULT < 32'sd1 ||
        (ROUNDS % UNROLL) != 32'sd0) begin : g_bad_cfg
        $error("cubehash_perm: UNROLL must be >= 1 and divide ROUNDS");
    end

    fsm_t          fsm_r;
    logic [CW-1:0] cnt_r;
    state_t        state_r;
    logic          busy_r;
    logic          done_r;
    state_t        load_s;
    logic [CW-1:0] load_cnt_s;
    state_t        chain_s [UNROLL+1];

    assign chain_s[0] = state_r;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        cubehash_round u_round (
            .state_in  (chain_s[u]),
            .state_out (chain_s[u+1])
        );
    end

    // Load value and cycle budget for a newly accepted call.
    always_comb begin
        load_s     = state_in;
        load_cnt_s = CNT_NORM;
        if (fin) begin
            load_s[1023:992] = state_in[1023:992] ^ FIN_XOR;
            load_cnt_s       = CNT_FIN;
        end else begin
            load_s[1023:992] = state_in[1023:992];
            load_cnt_s       = CNT_NORM;
        end
    end

    // Control FSM and working state register; done is cleared by the
    // IDLE branch so a start in the done cycle is accepted back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r   <= IDLE;
            cnt_r   <= '0;
            state_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= load_s;
                        cnt_r   <= load_cnt_s;
                        busy_r  <= 1'b1;
                        fsm_r   <= RUN;
                    end
                end
                RUN: begin
                    state_r <= chain_s[UNROLL];
                    if (cnt_r == '0) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        fsm_r  <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    fsm_r  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign state_out = state_r;

endmodule

// File: tb/tb_cubehash_perm.sv
// Directed bench for cubehash_perm: UNROLL=1 and UNROLL=2 builds side by side,
// expected states from an independent word-level model held in scoreboards.
`timescale 1ns/1ps
module tb_cubehash_perm;

    typedef struct {
        logic [1023:0] st;
        int            lat;
        int            launch;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic          fin = 1'b0;
    logic [1023:0] state_in = '0;
    logic          busy1, done1, busy2, done2;
    logic [1023:0] state_out1, state_out2;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    logic [1023:0] s, e, iv;
    int   lc, bcnt;

    cubehash_perm #(.ROUNDS(16), .UNROLL(1), .FIN_MULT(10)) dut1 (
        .clk(clk), .rst(rst), .start(start), .fin(fin), .state_in(state_in),
        .busy(busy1), .done(done1), .state_out(state_out1)
    );

    cubehash_perm #(.ROUNDS(16), .UNROLL(2), .FIN_MULT(10)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .fin(fin), .state_in(state_in),
        .busy(busy2), .done(done2), .state_out(state_out2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference round written directly from the word-index description.
    function automatic logic [1023:0] m_round(input logic [1023:0] st);
        logic [31:0]   w [32];
        logic [31:0]   tmp;
        logic [1023:0] r;
        int a;
        for (int n = 0; n < 32; n++) w[n] = st[32*n +: 32];
        for (int n = 0; n < 16; n++) w[16+n] = w[16+n] + w[n];
        for (int n = 0; n < 16; n++) w[n] = {w[n][24:0], w[n][31:25]};
        for (int k = 0; k < 2; k++) for (int l = 0; l < 2; l++) for (int m = 0; m < 2; m++) begin
            a = k*4 + l*2 + m; tmp = w[a]; w[a] = w[8+a]; w[8+a] = tmp;
        end
        for (int n = 0; n < 16; n++) w[n] = w[n] ^ w[16+n];
        for (int j = 0; j < 2; j++) for (int k = 0; k < 2; k++) for (int m = 0; m < 2; m++) begin
            a = 16 + j*8 + k*4 + m; tmp = w[a]; w[a] = w[a+2]; w[a+2] = tmp;
        end
        for (int n = 0; n < 16; n++) w[16+n] = w[16+n] + w[n];
        for (int n = 0; n < 16; n++) w[n] = {w[n][20:0], w[n][31:21]};
        for (int j = 0; j < 2; j++) for (int l = 0; l < 2; l++) for (int m = 0; m < 2; m++) begin
            a = j*8 + l*2 + m; tmp = w[a]; w[a] = w[a+4]; w[a+4] = tmp;
        end
        for (int n = 0; n < 16; n++) w[n] = w[n] ^ w[16+n];
        for (int j = 0; j < 2; j++) for (int k = 0; k < 2; k++) for (int l = 0; l < 2; l++) begin
            a = 16 + j*8 + k*4 + l*2; tmp = w[a]; w[a] = w[a+1]; w[a+1] = tmp;
        end
        for (int n = 0; n < 32; n++) r[32*n +: 32] = w[n];
        return r;
    endfunction

    function automatic logic [1023:0] m_perm(input logic [1023:0] st, input int rounds);
        logic [1023:0] r;
        r = st;
        for (int n = 0; n < rounds; n++) r = m_round(r);
        return r;
    endfunction

    function automatic logic [1023:0] rnd_state();
        logic [1023:0] r;
        for (int n = 0; n < 32; n++) r[32*n +: 32] = $urandom;
        return r;
    endfunction

    function automatic int diff_word(input logic [1023:0] a, input logic [1023:0] b);
        for (int n = 0; n < 32; n++) if (a[32*n +: 32] !== b[32*n +: 32]) return n;
        return 0;
    endfunction

    // Scoreboard check for the UNROLL=1 build.
    always @(negedge clk) begin
        if (!rst && done1) begin
            n_vec++;
            assert (q1.size() != 0) else begin
                n_err++; $error("FAIL done1_unexpected observed=done expected=no_done cycle=%0d", cyc);
            end
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                n_vec++;
                assert (state_out1 === e1.st) else begin
                    n_err++;
                    $error("FAIL state1 word%0d observed=%h expected=%h", diff_word(state_out1, e1.st),
                           state_out1[32*diff_word(state_out1, e1.st) +: 32], e1.st[32*diff_word(state_out1, e1.st) +: 32]);
                end
                n_vec++;
                assert (cyc - e1.launch === e1.lat) else begin
                    n_err++; $error("FAIL latency1 observed=%0d expected=%0d", cyc - e1.launch, e1.lat);
                end
            end
        end
    end

    // Scoreboard check for the UNROLL=2 build.
    always @(negedge clk) begin
        if (!rst && done2) begin
            n_vec++;
            assert (q2.size() != 0) else begin
                n_err++; $error("FAIL done2_unexpected observed=done expected=no_done cycle=%0d", cyc);
            end
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                n_vec++;
                assert (state_out2 === e2.st) else begin
                    n_err++;
                    $error("FAIL state2 word%0d observed=%h expected=%h", diff_word(state_out2, e2.st),
                           state_out2[32*diff_word(state_out2, e2.st) +: 32], e2.st[32*diff_word(state_out2, e2.st) +: 32]);
                end
                n_vec++;
                assert (cyc - e2.launch === e2.lat) else begin
                    n_err++; $error("FAIL latency2 observed=%0d expected=%0d", cyc - e2.launch, e2.lat);
                end
            end
        end
    end

    // Called at a negedge: queue the expected result, then hold start over one edge.
    task automatic launch(input logic [1023:0] st, input logic f, input bit both, output logic [1023:0] ex);
        exp_t x;
        logic [1023:0] ld;
        ld = st;
        if (f) ld[1023:992] = ld[1023:992] ^ 32'h0000_0001;
        ex = m_perm(ld, f ? 160 : 16);
        x.st = ex; x.launch = cyc; x.lat = f ? 161 : 17;
        q1.push_back(x);
        if (both) begin
            x.lat = f ? 81 : 9;
            q2.push_back(x);
        end
        state_in = st; fin = f; start = 1'b1; start2 = both;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0; fin = 1'b0; state_in = rnd_state();
    endtask

    task automatic pulse_ignored(input string tag);
        n_vec++;
        assert (busy1 === 1'b1) else begin
            n_err++; $error("FAIL %s_busy observed=%b expected=1", tag, busy1);
        end
        state_in = rnd_state(); fin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fin = 1'b0;
    endtask

    task automatic wait_done1(input string tag);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!done1 && k < 300);
        n_vec++;
        assert (done1 === 1'b1) else begin
            n_err++; $error("FAIL %s_timeout observed=%b expected=1", tag, done1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((q1.size() != 0 || q2.size() != 0) && k < 400) begin @(negedge clk); k++; end
        @(negedge clk);
        n_vec++;
        assert (q1.size() == 0 && q2.size() == 0) else begin
            n_err++; $error("FAIL %s_timeout observed=%0d/%0d pending expected=0/0", tag, q1.size(), q2.size());
        end
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        assert (busy1 === 1'b0 && done1 === 1'b0 && state_out1 === '0) else begin
            n_err++; $error("FAIL %s_dut1 observed=busy%b done%b nz%b expected=busy0 done0 nz0", tag, busy1, done1, |state_out1);
        end
        n_vec++;
        assert (busy2 === 1'b0 && done2 === 1'b0 && state_out2 === '0) else begin
            n_err++; $error("FAIL %s_dut2 observed=busy%b done%b nz%b expected=busy0 done0 nz0", tag, busy2, done2, |state_out2);
        end
    endtask

    initial begin
        // Reset, with start held high to show reset dominates.
        state_in = rnd_state(); start = 1'b1; start2 = 1'b1; fin = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        start = 1'b0; start2 = 1'b0; fin = 1'b0; rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Zero state is a fixed point; busy high for 16 cycles.
        launch('0, 1'b0, 1'b1, e);
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done1) break;
            if (busy1) bcnt++;
        end
        n_vec++;
        assert (bcnt === 16) else begin
            n_err++; $error("FAIL busy_cycles observed=%0d expected=16", bcnt);
        end
        wait_idle("zero");

        // Ten back-to-back calls from the 256-bit CubeHash parameter block give the IV.
        iv = '0; iv[31:0] = 32'h20; iv[63:32] = 32'h20; iv[95:64] = 32'h10;
        @(negedge clk);
        launch(iv, 1'b0, 1'b0, e);
        for (int c = 1; c < 10; c++) begin
            wait_done1("iv_chain");
            launch(e, 1'b0, 1'b0, e);
        end
        wait_done1("iv_last");
        n_vec++;
        assert (state_out1[31:0] === 32'hEA2BD4B4) else begin
            n_err++; $error("FAIL iv_word0 observed=%h expected=ea2bd4b4", state_out1[31:0]);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        assert (state_out1 === e && busy1 === 1'b0) else begin
            n_err++; $error("FAIL hold_after_done observed=%h expected=%h", state_out1[31:0], e[31:0]);
        end

        // Random state through both builds.
        for (int t = 0; t < 2; t++) begin
            launch(rnd_state(), 1'b0, 1'b1, e);
            wait_idle("random");
        end

        // Finalisation from zero.
        launch('0, 1'b1, 1'b1, e);
        wait_idle("fin");
        n_vec++;
        assert (state_out1 !== '0) else begin
            n_err++; $error("FAIL fin_nonzero observed=%h expected=nonzero", state_out1[31:0]);
        end

        // Starts during RUN are ignored.
        s = rnd_state();
        lc = cyc;
        launch(s, 1'b0, 1'b0, e);
        while (cyc < lc + 3) @(negedge clk);
        pulse_ignored("pulse3");
        while (cyc < lc + 8) @(negedge clk);
        pulse_ignored("pulse8");
        while (cyc < lc + 16) @(negedge clk);
        pulse_ignored("pulse16");
        wait_idle("ignored");
        repeat (25) @(negedge clk);
        n_vec++;
        assert (busy1 === 1'b0 && state_out1 === e) else begin
            n_err++; $error("FAIL ignored_start observed=busy%b w0=%h expected=busy0 w0=%h", busy1, state_out1[31:0], e[31:0]);
        end

        // Reset mid-call aborts without done, then a fresh call works.
        lc = cyc;
        launch(rnd_state(), 1'b0, 1'b1, e);
        while (cyc < lc + 6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        q1.delete();
        q2.delete();
        repeat (20) @(negedge clk);
        check_zero("post_abort");
        launch(rnd_state(), 1'b0, 1'b1, e);
        wait_idle("after_abort");
        launch(rnd_state(), 1'b1, 1'b1, e);
        wait_idle("fin_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cubehash_perm.md
# cubehash_perm

Iterative, parametrised CubeHash permutation engine over the 1024-bit state (32 × 32-bit words). It is the successor to the fixed single-round F-block. It adds a start/busy/done handshake, a configurable number of rounds per call, configurable rounds per clock, and a finalisation mode. It sits between the message-absorb logic and the digest-output logic of the hash core.

## Interface
- ROUNDS, 16: rounds per normal call (CubeHash r); ≥1.
- UNROLL, 1: rounds applied per clock; must divide ROUNDS; elaboration error otherwise.
- FIN_MULT, 10: finalisation runs FIN_MULT×ROUNDS rounds.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a permutation call; accepted only when busy=0.
- fin  input  1  sampled with start; 1 = finalisation call.
- state_in  input  1024  input state; word n = state_in[32n+31:32n].
- busy  output  1  call in progress.
- done  output  1  one-cycle pulse; state_out holds the result.
- state_out  output  1024  working state register, same word layout.

## Operation
- Word index bits i,j,k,l,m (i = bit 4, m = bit 0). One round, all additions mod 2^32:
  1. x[1jklm] += x[0jklm]
  2. x[0jklm] rotl 7
  3. swap x[00klm] ↔ x[01klm]
  4. x[0jklm] ^= x[1jklm]
  5. swap x[1jk0m] ↔ x[1jk1m]
  6. x[1jklm] += x[0jklm]
  7. x[0jklm] rotl 11
  8. swap x[0j0lm] ↔ x[0j1lm]
  9. x[0jklm] ^= x[1jklm]
  10. swap x[1jkl0] ↔ x[1jkl1]
- FSM has two states:
  - IDLE: busy=0. On start, load state_in into the register. If fin=1, XOR 32'h1 into word 31 at load. Set the cycle counter to N−1, where N = ROUNDS/UNROLL (normal) or FIN_MULT·ROUNDS/UNROLL (fin). Go to RUN.
  - RUN: busy=1. Each clock, apply UNROLL chained rounds to the register. When the counter = 0, pulse done and go to IDLE; otherwise decrement the counter.
- start while busy=1 is ignored; fin has no effect without start.
- state_out is the working register. It changes only on the load edge and during RUN, and is stable from done until the next accepted start.
- Reset: state register = 0, counter = 0, FSM = IDLE, busy = 0, done = 0. Reset dominates start on the same edge. Reset mid-RUN aborts the call with no done pulse.

## Timing
- Start sampled high at edge E0 (IDLE): load at E0; busy=1 after E0.
- Rounds are applied at edges E1..EN.
- After EN: done=1 for exactly one cycle, busy=0, and state_out holds the final state.
- Latency from start to done is N+1 cycles:
  - ROUNDS=16, UNROLL=1: 17 cycles normal, 161 cycles fin.
  - UNROLL=2: 9 cycles normal, 81 cycles fin.
- A start in the done cycle is accepted (back-to-back calls, one idle-free gap). done then drops and busy rises after that edge.
- Counter width is $clog2(FIN_MULT·ROUNDS/UNROLL).

## Structure
- Shared package cubehash_pkg holds:
  - word/state typedefs;
  - rotation constants 7 and 11;
  - the finalisation XOR constant;
  - a pure function for one round on a 1024-bit state, reused by the reference model hooks.
- Sub-module cubehash_round: a purely combinational single round. Instantiate it UNROLL times in a generate chain feeding the state register.

## Test plan
- All-zero state_in, fin=0 → done after 17 cycles, state_out = 0 (zero is a fixed point); busy high for 16 cycles.
- state_in word0=32'h20, word1=32'h20, word2=32'h10, rest 0; ten back-to-back fin=0 calls (ROUNDS=16) → word0 = 32'hEA2BD4B4 (CubeHash16/32-256 IV); full state matches the software model.
- Same random state, UNROLL=1 vs UNROLL=2 builds → identical state_out; done at cycle 17 vs 9.
- Zero state, fin=1 → 161-cycle latency; state_out ≠ 0 and matches the model of (word31 ^= 1) plus 160 rounds.
- start pulsed at cycles 3, 8 and 16 during RUN → ignored; the single done carries the first call's result.
- rst asserted at cycle 6 of a call → next cycle busy=0, done=0, state_out=0, with no done pulse; a fresh start afterwards gives correct results.
